// File: rtl/stream_fifo_ram_ctrl.sv
// Stream FIFO controller around an external 1-write/1-sync-read RAM (read latency 1),
// with a 2-entry output stage; define STREAM_FIFO_BYPASS_EN for the empty-FIFO bypass path.
module stream_fifo_ram_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_payload,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_payload,
  output logic [AW+1:0]    occupancy,
  output logic             ram_wr_en,
  output logic             ram_wr_mask,
  output logic [AW-1:0]    ram_wr_addr,
  output logic [WIDTH-1:0] ram_wr_data,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_rd_addr,
  input  logic [WIDTH-1:0] ram_rd_data
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      ram_count_s;
  logic [WIDTH-1:0] out_q_r     [2];
  logic [WIDTH-1:0] out_q_nxt_s [2];
  logic [1:0]       out_count_r;
  logic [1:0]       out_count_nxt_s;
  logic [1:0]       kept_count_s;
  logic             rd_pending_r;
  logic             push_fire_s;
  logic             pop_fire_s;
  logic             ram_write_s;
  logic             rd_issue_s;
  logic             bypass_s;
  logic             append_s;
  logic [WIDTH-1:0] append_data_s;
  logic [2:0]       rd_level_s;

  assign ram_count_s  = wr_ptr_r - rd_ptr_r;
  assign push_ready   = resetn && (ram_count_s != FULL_CNT);
  assign pop_valid    = resetn && (out_count_r != 2'd0);
  assign pop_payload  = out_q_r[0];
  assign push_fire_s  = push_valid && push_ready;
  assign pop_fire_s   = pop_valid && pop_ready;
  assign kept_count_s = out_count_r - {1'b0, pop_fire_s};

  // Output-stage slots already spoken for after this cycle's pop; a read may only claim a free one.
  assign rd_level_s = {1'b0, out_count_r} + {2'b00, rd_pending_r} - {2'b00, pop_fire_s};
  assign rd_issue_s = resetn && (ram_count_s != ZERO_CNT) && (rd_level_s < 3'd2);

`ifdef STREAM_FIFO_BYPASS_EN
  assign bypass_s = (ram_count_s == ZERO_CNT) && !rd_pending_r && (kept_count_s < 2'd2);
`else
  assign bypass_s = 1'b0;
`endif

  assign ram_write_s   = push_fire_s && !bypass_s;
  assign append_s      = rd_pending_r || (push_fire_s && bypass_s);
  assign append_data_s = rd_pending_r ? ram_rd_data : push_payload;

  assign ram_wr_en   = ram_write_s;
  assign ram_wr_mask = 1'b1;
  assign ram_wr_addr = wr_ptr_r[AW-1:0];
  assign ram_wr_data = push_payload;
  assign ram_rd_en   = rd_issue_s;
  assign ram_rd_addr = rd_ptr_r[AW-1:0];
  assign occupancy   = resetn ? ({1'b0, ram_count_s} + {{(AW+1){1'b0}}, rd_pending_r}
                                 + {{AW{1'b0}}, out_count_r})
                              : {(AW+2){1'b0}};

  // Output queue next state: pop shifts the head out, then an append lands behind the survivors.
  always_comb begin
    out_q_nxt_s     = out_q_r;
    out_count_nxt_s = kept_count_s;
    if (pop_fire_s) begin
      out_q_nxt_s[0] = out_q_r[1];
    end else begin
      out_q_nxt_s[0] = out_q_r[0];
    end
    if (append_s) begin
      out_q_nxt_s[kept_count_s[0]] = append_data_s;
      out_count_nxt_s              = kept_count_s + 2'd1;
    end else begin
      out_count_nxt_s = kept_count_s;
    end
  end

  // Pointer, in-flight read flag and output queue registers; reset discards any read in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r     <= ZERO_CNT;
      rd_ptr_r     <= ZERO_CNT;
      rd_pending_r <= 1'b0;
      out_count_r  <= 2'd0;
      out_q_r[0]   <= {WIDTH{1'b0}};
      out_q_r[1]   <= {WIDTH{1'b0}};
    end else begin
      if (ram_write_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_CNT;
      end
      if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_CNT;
      end
      rd_pending_r <= rd_issue_s;
      out_count_r  <= out_count_nxt_s;
      out_q_r      <= out_q_nxt_s;
    end
  end

endmodule

// File: tb/tb_stream_fifo_ram_ctrl.sv
// Scoreboard bench for stream_fifo_ram_ctrl with a behavioural 1-cycle-latency RAM;
// latency expectations follow STREAM_FIFO_BYPASS_EN.
module tb_stream_fifo_ram_ctrl;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
`ifdef STREAM_FIFO_BYPASS_EN
  localparam int   LAT       = 1;
  localparam logic FIRST_RAM = 1'b0;
`else
  localparam int   LAT       = 3;
  localparam logic FIRST_RAM = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             push_valid = 1'b0;
  logic             push_ready;
  logic [WIDTH-1:0] push_payload = '0;
  logic             pop_valid;
  logic             pop_ready = 1'b0;
  logic [WIDTH-1:0] pop_payload;
  logic [AW+1:0]    occupancy;
  logic             ram_wr_en;
  logic             ram_wr_mask;
  logic [AW-1:0]    ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data = '0;
  logic [WIDTH-1:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sb [$];

  stream_fifo_ram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready), .push_payload(push_payload),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_payload(pop_payload),
    .occupancy(occupancy),
    .ram_wr_en(ram_wr_en), .ram_wr_mask(ram_wr_mask), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Ram_1w_1rs stand-in: synchronous write, registered read data.
  always @(posedge clk) begin
    if (ram_wr_en && ram_wr_mask) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic cycle(input logic pv, input logic [WIDTH-1:0] pd, input logic pr, input logic rn);
    @(negedge clk);
    push_valid = pv; push_payload = pd; pop_ready = pr; resetn = rn;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h11, 1'b0, 1'b0);
      checks++;
      if ({push_ready, pop_valid, ram_wr_en, ram_rd_en} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_strobes: got rdy/vld/wr/rd=%b, expected 0000",
                 {push_ready, pop_valid, ram_wr_en, ram_rd_en});
      end
      checks++;
      if (occupancy !== 6'd0) begin
        errors++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (pop_valid !== 1'b0 || occupancy !== 6'd0) begin
        errors++; $display("FAIL post_reset_idle: got vld=%b occ=%0d, expected 0/0", pop_valid, occupancy);
      end
    end
  endtask

  task automatic test_single_word();
    logic seen = 1'b0;
    logic occ_done = 1'b0;
    logic [WIDTH-1:0] exp;
    cycle(1'b1, 32'hA5, 1'b1, 1'b1);
    checks++;
    if (push_ready !== 1'b1 || ram_wr_en !== FIRST_RAM) begin
      errors++; $display("FAIL single_push: got rdy=%b wr_en=%b, expected 1/%b", push_ready, ram_wr_en, FIRST_RAM);
    end
    if (push_valid && push_ready) sb.push_back(push_payload);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (pop_valid && !seen) begin
        seen = 1'b1;
        checks++;
        if (k != LAT) begin
          errors++; $display("FAIL single_latency: got %0d cycles, expected %0d", k, LAT);
        end
        exp = sb.pop_front();
        checks++;
        if (pop_payload !== exp) begin
          errors++; $display("FAIL single_data: got %h, expected %h", pop_payload, exp);
        end
      end else if (seen && !occ_done) begin
        occ_done = 1'b1;
        checks++;
        if (occupancy !== 6'd0 || pop_valid !== 1'b0) begin
          errors++; $display("FAIL single_drained: got occ=%0d vld=%b, expected 0/0", occupancy, pop_valid);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL single_timeout: got no pop_valid in 10 cycles, expected one at %0d", LAT);
    end
  endtask

  task automatic test_fill();
    int accepted = 0;
    int first_rd = -1;
    int first_rdy = -1;
    logic [WIDTH-1:0] exp;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, WIDTH'(i), 1'b0, 1'b1);
      if (push_valid && push_ready) begin sb.push_back(push_payload); accepted++; end
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (accepted != DEPTH + 2) begin
      errors++; $display("FAIL fill_accepted: got %0d, expected %0d", accepted, DEPTH + 2);
    end
    checks++;
    if (push_ready !== 1'b0 || occupancy !== 6'(DEPTH + 2) || pop_valid !== 1'b1) begin
      errors++; $display("FAIL fill_full_state: got rdy=%b occ=%0d vld=%b, expected 0/%0d/1",
                         push_ready, occupancy, pop_valid, DEPTH + 2);
    end
    for (int k = 0; k < 60 && sb.size() > 0; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (ram_rd_en && first_rd < 0) first_rd = k;
      if (push_ready && first_rdy < 0) first_rdy = k;
      if (pop_valid) begin
        exp = sb.pop_front();
        checks++;
        if (pop_payload !== exp) begin
          errors++; $display("FAIL fill_order: got %h, expected %h", pop_payload, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL fill_drain_timeout: got %0d words left, expected 0", sb.size());
    end
    checks++;
    if (first_rd < 0 || first_rdy != first_rd + 1) begin
      errors++; $display("FAIL fill_ready_return: got ready at %0d read at %0d, expected ready one after read",
                         first_rdy, first_rd);
    end
  endtask

  task automatic test_back_to_back();
    int next = 0;
    int popped = 0;
    int gaps = 0;
    int first_k = -1;
    logic [WIDTH-1:0] exp;
    for (int k = 0; k < 300 && popped < 100; k++) begin
      cycle(next < 100, WIDTH'(next), 1'b1, 1'b1);
      if (first_k >= 0 && !pop_valid) gaps++;
      if (pop_valid) begin
        if (first_k < 0) first_k = k;
        popped++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %h, expected no word", pop_payload);
        end else begin
          exp = sb.pop_front();
          if (pop_payload !== exp) begin
            errors++; $display("FAIL stream_order: got %h, expected %h", pop_payload, exp);
          end
        end
      end
      if (push_valid && push_ready) begin sb.push_back(push_payload); next++; end
    end
    checks++;
    if (popped != 100 || gaps != 0) begin
      errors++; $display("FAIL stream_continuous: got %0d words %0d gaps, expected 100/0", popped, gaps);
    end
    checks++;
    if (first_k != LAT) begin
      errors++; $display("FAIL stream_latency: got first pop at %0d, expected %0d", first_k, LAT);
    end
  endtask

  task automatic test_random_wrap();
    int accepted = 0;
    int wr_wraps = 0;
    int rd_wraps = 0;
    int max_occ = 0;
    logic pv;
    logic pr;
    logic [WIDTH-1:0] exp;
    for (int c = 0; c < 20000 && (accepted < 1000 || sb.size() > 0); c++) begin
      pv = (accepted < 1000) && ($urandom_range(3) != 0);
      pr = (accepted >= 1000) || ($urandom_range(1) == 1);
      cycle(pv, $urandom, pr, 1'b1);
      checks++;
      if (occupancy !== 6'(sb.size())) begin
        errors++; $display("FAIL rand_occupancy: got %0d, expected %0d", occupancy, sb.size());
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (ram_wr_en) begin
        checks++;
        if (ram_wr_data !== push_payload || ram_wr_mask !== 1'b1) begin
          errors++; $display("FAIL rand_wr_data: got %h mask %b, expected %h mask 1",
                             ram_wr_data, ram_wr_mask, push_payload);
        end
        if (ram_wr_addr == AW'(DEPTH - 1)) wr_wraps++;
      end
      if (ram_rd_en && ram_rd_addr == AW'(DEPTH - 1)) rd_wraps++;
      if (pop_valid && pop_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h, expected no word", pop_payload);
        end else begin
          exp = sb.pop_front();
          if (pop_payload !== exp) begin
            errors++; $display("FAIL rand_order: got %h, expected %h", pop_payload, exp);
          end
        end
      end
      if (push_valid && push_ready) begin sb.push_back(push_payload); accepted++; end
    end
    checks++;
    if (accepted != 1000 || sb.size() != 0) begin
      errors++; $display("FAIL rand_complete: got %0d accepted %0d left, expected 1000/0", accepted, sb.size());
    end
    checks++;
    if (wr_wraps < 50 || rd_wraps < 50) begin
      errors++; $display("FAIL rand_wraps: got wr=%0d rd=%0d, expected both >= 50", wr_wraps, rd_wraps);
    end
    checks++;
    if (max_occ > DEPTH + 2) begin
      errors++; $display("FAIL rand_max_occ: got %0d, expected <= %0d", max_occ, DEPTH + 2);
    end
  endtask

  task automatic test_reset_mid_read();
    logic found = 1'b0;
    logic seen = 1'b0;
    logic [WIDTH-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'hC0DE0000 + WIDTH'(i), 1'b0, 1'b1);
      if (push_valid && push_ready) sb.push_back(push_payload);
    end
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (ram_rd_en) found = 1'b1;
      if (pop_valid) begin
        exp = sb.pop_front();
        checks++;
        if (pop_payload !== exp) begin
          errors++; $display("FAIL midrst_pre_order: got %h, expected %h", pop_payload, exp);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midrst_no_read: got no ram_rd_en, expected one");
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if (pop_valid !== 1'b0 || occupancy !== 6'd0) begin
        errors++; $display("FAIL midrst_stale: got vld=%b data=%h occ=%0d, expected empty",
                           pop_valid, pop_payload, occupancy);
      end
    end
    cycle(1'b1, 32'h5A, 1'b1, 1'b1);
    if (push_valid && push_ready) sb.push_back(push_payload);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (pop_valid) begin
        seen = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL midrst_extra: got %h, expected no word", pop_payload);
        end else begin
          exp = sb.pop_front();
          if (pop_payload !== exp) begin
            errors++; $display("FAIL midrst_after: got %h, expected %h", pop_payload, exp);
          end
        end
      end
    end
    checks++;
    if (!seen || sb.size() != 0) begin
      errors++; $display("FAIL midrst_recover: got seen=%b left=%0d, expected 1/0", seen, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_back_to_back();
    test_random_wrap();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
